// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider bank.
// Divisors below MIN_DIV are raised to MIN_DIV so a channel always has a
// reachable wrap point and a well-defined square wave.
package clk_div_pkg;

    localparam int MIN_DIV          = 2;
    localparam int DEFAULT_CHANNELS = 4;

    // Width of the channel-select field; a single channel still gets one bit.
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    localparam int DEFAULT_CH_W = ch_width(DEFAULT_CHANNELS);

    // Truncate to the divisor width, then raise anything below MIN_DIV.
    function automatic logic [31:0] clamp_div(input logic [31:0] value, input int width);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        v    = value & mask;
        return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow divisor pair, registered tick
// and square-wave outputs. The shadow divisor moves to active only at a wrap.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 17,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_div_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pending_o
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(clamp_div(32'(DEFAULT_DIV), WIDTH));

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_shd_q, div_shd_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wrap;
    logic             half_hit;

    assign wrap     = (count_q == (div_act_q - WIDTH'(1)));
    assign half_hit = (count_q == ((div_act_q >> 1) - WIDTH'(1)));

    always_comb begin
        count_d   = count_q;
        div_act_d = div_act_q;
        div_shd_d = div_shd_q;
        tick_d    = 1'b0;
        sq_d      = sq_q;

        if (wr_i) begin
            div_shd_d = wr_div_i;
        end

        // Disabled and sync share the same restart; both load the old shadow
        // value so a write on this edge lands one cycle later.
        if (!en_i || sync_i) begin
            count_d   = '0;
            div_act_d = div_shd_q;
            sq_d      = 1'b0;
        end else if (wrap) begin
            count_d   = '0;
            div_act_d = div_shd_q;
            tick_d    = 1'b1;
            sq_d      = 1'b1;
        end else begin
            count_d = count_q + WIDTH'(1);
            if (half_hit) begin
                sq_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            div_act_q <= RESET_DIV;
            div_shd_q <= RESET_DIV;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            div_act_q <= div_act_d;
            div_shd_q <= div_shd_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
        end
    end

    assign tick_o    = tick_q;
    assign sq_o      = sq_q;
    assign pending_o = (div_shd_q != div_act_q);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one write port
// and one phase-align strobe; all outputs are clock_in-domain levels/enables.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 17,
    parameter int DEFAULT_DIV = 100000,
    localparam int CH_W       = ch_width(CHANNELS)
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq_out,
    output logic [CHANNELS-1:0] pending
);

    // Write port: wr_en is a single-cycle strobe with no backpressure; wr_ch and
    // wr_div are sampled on the same rising edge. Addresses with no matching
    // channel decode to no strobe and are dropped.
    logic [WIDTH-1:0] wr_div_clamped;

    assign wr_div_clamped = WIDTH'(clamp_div(32'(wr_div), WIDTH));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = wr_en && (wr_ch == CH_W'(i));

        clk_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clock_in  (clock_in),
            .reset     (reset),
            .en_i      (en[i]),
            .sync_i    (sync),
            .wr_i      (wr_sel),
            .wr_div_i  (wr_div_clamped),
            .tick_o    (tick[i]),
            .sq_o      (sq_out[i]),
            .pending_o (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank with DEFAULT_DIV reduced to 4 so
// periods stay short; expected tick/sq/pending values come from a period model.
module tb_clk_div_bank;

    localparam int CHANNELS    = 4;
    localparam int WIDTH       = 17;
    localparam int DEFAULT_DIV = 4;

    logic                clock_in;
    logic                reset;
    logic [CHANNELS-1:0] en;
    logic                sync;
    logic                wr_en;
    logic [1:0]          wr_ch;
    logic [WIDTH-1:0]    wr_div;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] sq_out;
    logic [CHANNELS-1:0] pending;

    int         tests_run;
    int         tests_failed;
    logic [1:0] exp_q[$];

    clk_div_bank #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .tick     (tick),
        .sq_out   (sq_out),
        .pending  (pending)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    // {tick, sq} after the k-th edge of a period-d run that started at count 0.
    function automatic logic [1:0] model(input int k, input int d);
        logic t;
        logic s;
        t = (k >= 1) && ((k % d) == 0);
        s = (k >= d) && ((k % d) < (d / 2));
        return {t, s};
    endfunction

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic write_div(input int ch, input int d);
        wr_en  = 1'b1;
        wr_ch  = 2'(ch);
        wr_div = WIDTH'(d);
        step();
        wr_en  = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] got;
        logic [1:0] exp;
        reset = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        repeat (3) @(posedge clock_in);
        #1;
        tests_run++;
        if (tick !== 4'b0) begin tests_failed++; $display("FAIL reset_tick got %b expected 0000", tick); end
        tests_run++;
        if (sq_out !== 4'b0) begin tests_failed++; $display("FAIL reset_sq got %b expected 0000", sq_out); end
        tests_run++;
        if (pending !== 4'b0) begin tests_failed++; $display("FAIL reset_pending got %b expected 0000", pending); end
        reset = 1'b0;
        en    = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(model(k, DEFAULT_DIV));
            step();
            got = {tick[0], sq_out[0]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL basic_ch0 k=%0d got %b expected %b", k, got, exp); end
        end
    endtask

    task automatic test_reprogram();
        logic [1:0] got;
        logic [1:0] exp;
        en = 4'b0000;
        step();
        en = 4'b0001;
        step();
        step();
        write_div(0, 6);
        tests_run++;
        if ({tick[0], pending[0]} !== 2'b01) begin
            tests_failed++; $display("FAIL reprog_pending_mid got %b expected 01", {tick[0], pending[0]});
        end
        step();
        tests_run++;
        if ({tick[0], sq_out[0], pending[0]} !== 3'b110) begin
            tests_failed++; $display("FAIL reprog_wrap got %b expected 110", {tick[0], sq_out[0], pending[0]});
        end
        for (int j = 1; j <= 12; j++) begin
            exp_q.push_back({(j % 6) == 0, (j % 6) < 3});
            step();
            got = {tick[0], sq_out[0]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL reprog_d6 j=%0d got %b expected %b", j, got, exp); end
        end
        tests_run++;
        if (pending[0] !== 1'b0) begin tests_failed++; $display("FAIL reprog_pending_end got %b expected 0", pending[0]); end
    endtask

    task automatic test_clamp();
        logic [1:0] got;
        logic [1:0] exp;
        en = 4'b0000;
        write_div(1, 0);
        tests_run++;
        if (pending[1] !== 1'b1) begin tests_failed++; $display("FAIL clamp_pending_w0 got %b expected 1", pending[1]); end
        step();
        tests_run++;
        if (pending[1] !== 1'b0) begin tests_failed++; $display("FAIL clamp_loaded got %b expected 0", pending[1]); end
        write_div(1, 1);
        tests_run++;
        if (pending[1] !== 1'b0) begin tests_failed++; $display("FAIL clamp_w1_pending got %b expected 0", pending[1]); end
        step();
        en = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(model(k, 2));
            step();
            got = {tick[1], sq_out[1]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL clamp_d2 k=%0d got %b expected %b", k, got, exp); end
        end
    endtask

    task automatic test_sync();
        logic [1:0] got;
        logic [1:0] exp;
        en = 4'b0011;
        write_div(0, 5);
        write_div(1, 7);
        sync = 1'b1;
        step();
        sync = 1'b0;
        tests_run++;
        if ({tick[1:0], sq_out[1:0], pending[1:0]} !== 6'b0) begin
            tests_failed++; $display("FAIL sync_clear got %b expected 000000", {tick[1:0], sq_out[1:0], pending[1:0]});
        end
        for (int k = 1; k <= 35; k++) begin
            exp_q.push_back(model(k, 5));
            exp_q.push_back(model(k, 7));
            step();
            got = {tick[0], sq_out[0]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL sync_ch0 k=%0d got %b expected %b", k, got, exp); end
            got = {tick[1], sq_out[1]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL sync_ch1 k=%0d got %b expected %b", k, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] got;
        logic [1:0] exp;
        en = 4'b0000;
        step();
        en = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            if (k == 5) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_div = WIDTH'(3);
            end
            exp_q.push_back({(k == 5) || (k == 10) || (k == 13), (k >= 5) && (k < 10)});
            step();
            wr_en = 1'b0;
            got = {tick[0], pending[0]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL wrap_write k=%0d got %b expected %b", k, got, exp); end
        end
    endtask

    task automatic test_disabled();
        logic [1:0] got;
        logic [1:0] exp;
        en = 4'b0000;
        write_div(2, 3);
        tests_run++;
        if (pending[2] !== 1'b1) begin tests_failed++; $display("FAIL dis_pending_write got %b expected 1", pending[2]); end
        step();
        tests_run++;
        if (pending[2] !== 1'b0) begin tests_failed++; $display("FAIL dis_immediate got %b expected 0", pending[2]); end
        en = 4'b0100;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back(model(k, 3));
            step();
            got = {tick[2], sq_out[2]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL dis_d3 k=%0d got %b expected %b", k, got, exp); end
        end
    endtask

    task automatic test_reset_async();
        logic [1:0] got;
        logic [1:0] exp;
        en = 4'b0000;
        write_div(3, 10);
        step();
        en = 4'b1000;
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(model(k, 10));
            step();
            got = {tick[3], sq_out[3]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL rst_pre_d10 k=%0d got %b expected %b", k, got, exp); end
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({tick, sq_out, pending} !== 12'b0) begin
            tests_failed++; $display("FAIL rst_async got %b expected 0", {tick, sq_out, pending});
        end
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(model(k, DEFAULT_DIV));
            step();
            got = {tick[3], sq_out[3]};
            exp = exp_q.pop_front();
            tests_run++;
            if (got !== exp) begin tests_failed++; $display("FAIL rst_post_default k=%0d got %b expected %b", k, got, exp); end
        end
        tests_run++;
        if (pending[3] !== 1'b0) begin tests_failed++; $display("FAIL rst_pending got %b expected 0", pending[3]); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_reprogram();
        test_clamp();
        test_sync();
        test_back_to_back();
        test_disabled();
        test_reset_async();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock divider. It derives several independent slow timing signals from the single board clock, for example 50 MHz down to 500 Hz for display scanning or to a few Hz for single-stepping the pipelined CPU. Each channel provides a one-cycle tick and a square-wave output. The divisor is reprogrammed at runtime through a shadow register, and the new value takes effect glitch-free at the channel's next wrap. Sits between the board clock and the display/debug logic; outputs are synchronous enables/levels in the clock_in domain.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 17, counter and divisor width in bits
- DEFAULT_DIV, 100000, divisor loaded into every channel at reset (50 MHz -> 500 Hz)
- clock_in  input  1  board clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state to reset values
- en  input  CHANNELS  per-channel run enable
- sync  input  1  phase-align: restart all enabled channels together
- wr_en  input  1  divisor write strobe
- wr_ch  input  max(1,$clog2(CHANNELS))  channel addressed by write
- wr_div  input  WIDTH  new divisor (period in clock_in cycles)
- tick  output  CHANNELS  one-cycle pulse per period, per channel
- sq_out  output  CHANNELS  square wave per channel
- pending  output  CHANNELS  shadow divisor differs from active divisor

## Operation
- Per channel: count[WIDTH], div_act[WIDTH], div_shd[WIDTH]; tick and sq_out are registered.
- Divisor clamp: any written value < 2 is stored as 2. Writes with wr_ch >= CHANNELS are ignored.
- Write: wr_en stores the clamped wr_div into div_shd[wr_ch] only. div_act is never written directly.
- Enabled, no sync:
  - If count == div_act-1 (wrap): count<=0, div_act<=div_shd, tick<=1, sq_out<=1.
  - Else: count<=count+1, tick<=0. If count == (div_act>>1)-1, then sq_out<=0.
- sq_out is high for floor(D/2) cycles and low for ceil(D/2) cycles per period D.
- Disabled (en=0): count<=0, tick<=0, sq_out<=0, div_act<=div_shd every cycle, so a write takes effect immediately.
- sync=1: every enabled channel sets count<=0, div_act<=div_shd, tick<=0, sq_out<=0. sync has priority over wrap.
- Write on the same cycle as a wrap on the same channel: div_act loads the old div_shd. The new value takes effect at the following wrap.
- pending[i] = (div_shd[i] != div_act[i]), combinational from registers.

## Timing
- Reset values:
  - count=0, div_act=div_shd=DEFAULT_DIV (clamped).
  - tick=0, sq_out=0, pending=0.
- From reset release or en rising with count=0: the first tick is registered on the D-th rising edge. After that, tick recurs every D edges.
- tick width is exactly 1 clock_in cycle. tick and the sq_out rising edge coincide.
- Divisor change latency: at most D_old cycles (next wrap) when enabled; 1 cycle when disabled.
- Reset mid-period: all outputs drop asynchronously and the programmed divisors revert to DEFAULT_DIV.
- Counter never exceeds div_act-1; no wrap through 2^WIDTH.

## Structure
- Package clk_div_pkg:
  - MIN_DIV=2.
  - Function clamp_div(value, WIDTH).
  - Localparam for the wr_ch width.
- Sub-module clk_div_channel holds one channel's count/div_act/div_shd/tick/sq_out logic. The top instantiates CHANNELS copies with a generate loop and decodes wr_en/wr_ch to per-channel write strobes.

## Test plan
- Reset, en=1, DEFAULT_DIV overridden to 4 -> tick high on edges 4, 8, 12; sq_out pattern 1,1,0,0 repeating, starting at edge 4.
- Channel 0 at D=4, write D=6 mid-period -> pending=1 until the next wrap. After that: period 6, sq high 3 low 3, pending=0.
- Write D=0 and D=1 -> stored as 2; tick every 2 cycles; sq_out toggles each cycle.
- Channels 0/1 at D=5/D=7, pulse sync -> both counts zero. Ticks then on edge 5 and edge 7 after sync; the next coincident tick is 35 cycles after sync.
- en=0 on channel 2, write D=3 -> div_act=3 next cycle. Raise en -> first tick on the 3rd edge.
- Assert reset asynchronously mid-period with D=10 programmed -> outputs 0 immediately. After release, period = DEFAULT_DIV.
